wb_daq_sample_ram: RTL and testbench
====================================

Name: wb_daq_sample_ram

Overview:
- Wishbone B3 slave memory that terminates the DAQ bus master's sample writes. It is the responder end of the channel-to-memory write path.
- Stores 2^mem_aw 32-bit words and supports classic and incrementing-burst cycles with byte selects.
- Counts accepted write beats so software and the bench can check how many samples landed.
- Also serves reads, so stored samples can be fetched back over the same port.

Parameters:
- dw, 32, data width; only 32 is supported.
- aw, 32, bus address width.
- mem_aw, 10, log2 of the memory depth in words.
- base_addr, 32'h0000_0000, window base; must be aligned to 2^(mem_aw+2) bytes.

Ports:
- wb_clk  input  1  clock.
- wb_rst  input  1  reset; asynchronous, active-high.
- wb_adr_i  input  aw  byte address; bits [1:0] ignored.
- wb_dat_i  input  dw  write data.
- wb_sel_i  input  4  byte lane enables.
- wb_we_i  input  1  1 = write.
- wb_cyc_i  input  1  cycle valid.
- wb_stb_i  input  1  strobe.
- wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  input  2  burst wrap: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wb_dat_o  output  dw  read data.
- wb_ack_o  output  1  beat acknowledge.
- wb_err_o  output  1  address error.
- wb_rty_o  output  1  tied to 0.
- clear_count  input  1  synchronous clear of write_count.
- write_count  output  16  accepted write beats, saturating.

Behaviour:
- Reset:
  - All outputs are 0, the FSM is in IDLE and the internal beat address is 0.
  - Memory contents are not reset.
  - Reset asserted mid-burst aborts the burst; the write in that cycle is not performed.
- Decode:
  - in_range = (wb_adr_i[aw-1:mem_aw+2] == base_addr[aw-1:mem_aw+2]).
  - Word index = wb_adr_i[mem_aw+1:2].
- Output gating:
  - ack_q and err_q are registered.
  - wb_ack_o = ack_q & wb_cyc_i & wb_stb_i; wb_err_o = err_q & wb_cyc_i & wb_stb_i.
  - A beat is accepted on any rising edge where wb_ack_o = 1.
- FSM states: IDLE, CLASSIC, BURST, ERROR.
  - IDLE, when cyc & stb and out of range: go to ERROR and set err_q for exactly 1 cycle. No memory access occurs.
  - IDLE, when cyc & stb, in range and cti = 000 or 111: go to CLASSIC. Latch the address and set ack_q for 1 cycle. Latency from stb to ack is 1 clock; ack_q then drops for at least 1 cycle so ack never overlaps the next request.
  - IDLE, when cyc & stb, in range and cti = 010: go to BURST. Latch the start address and set ack_q.
  - IDLE, when cti = 001, 011, 100, 101 or 110: treat as classic.
  - BURST: ack_q stays 1 while cyc is high. On each accepted beat the internal address advances per bte.
    - bte = 00 (linear): the full mem_aw-bit word index increments and wraps 2^mem_aw-1 -> 0.
    - bte = 01 / 10 / 11: only the low 2 / 3 / 4 index bits increment; the upper index bits stay fixed.
    - wb_adr_i is ignored after the first beat.
  - BURST exit: an accepted beat with cti = 111 clears ack_q and returns to IDLE. cyc deasserting in any state also returns to IDLE with ack_q = 0.
  - BURST wait states: a stb deassertion does not exit; no beat is accepted, the address holds, and ack resumes in the same cycle stb returns.
  - ERROR: return to IDLE the next cycle.
- Write:
  - On an accepted beat with we = 1, each byte lane whose sel bit is 1 is written at the current beat address.
  - Lanes with sel = 0 are preserved.
  - A write with sel = 0000 is still acked and counted.
- Read:
  - wb_dat_o is registered and valid whenever ack is high.
  - In IDLE it is loaded from mem[word index of wb_adr_i].
  - On each accepted burst beat it is loaded from mem[next beat address], so bursts sustain 1 beat per clock with no bubble.
  - wb_dat_o holds its value when no beat is accepted.
- write_count:
  - Increments by 1 on each accepted write beat and saturates at 16'hFFFF.
  - clear_count takes priority: if clear and a write beat coincide, the result is 0.
- wb_rty_o is constant 0.

Test Plan:
- Reset then classic write: adr = base + 0x10, dat = 32'hDEADBEEF, sel = 1111 -> ack 1 clock after stb, 1 cycle wide; write_count = 1. Classic read of the same address -> dat_o = 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with sel = 1111, then 32'hAABBCCDD with sel = 0101 -> readback 32'h11BB33DD.
- Wrap-4 burst write starting at word 6 (adr 0x18), data 1..4, cti 010,010,010,111, bte = 01 -> words 6,7,4,5 hold 1,2,3,4; 4 consecutive acks; ack low after the 111 beat; write_count += 4.
- Linear burst read over 8 words with stb dropped for 2 cycles after beat 3 -> ack low for exactly those 2 cycles; 8 beats return the correct data in order; no address skip.
- Out-of-range access: adr = base + 2^(mem_aw+2) -> err high 1 cycle, ack stays 0, memory and write_count unchanged, rty always 0.
- Counter and reset: preload write_count to 16'hFFFF, then do a write -> stays 16'hFFFF. Assert clear_count in the same cycle as a write beat -> 0. Assert wb_rst mid-burst -> ack, err and write_count go to 0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/wb_daq_sample_ram.sv
// Wishbone B3 slave sample memory: terminates DAQ sample writes, serves
// read-back, supports classic and incrementing-burst cycles with byte
// selects, and counts accepted write beats (saturating).
module wb_daq_sample_ram #(
    parameter int unsigned   dw        = 32,
    parameter int unsigned   aw        = 32,
    parameter int unsigned   mem_aw    = 10,
    parameter logic [aw-1:0] base_addr = '0
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    input  logic          clear_count,
    output logic [15:0]   write_count
);

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERROR} state_t;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    logic [dw-1:0]     mem [0:(1<<mem_aw)-1];

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [mem_aw-1:0] addr_q, addr_d;
    logic [mem_aw-1:0] word_idx;
    logic [mem_aw-1:0] wrap_mask;
    logic [mem_aw-1:0] burst_next;
    logic [mem_aw-1:0] rd_addr;
    logic              rd_load;
    logic              req;
    logic              in_range;
    logic              beat;
    logic [15:0]       count_q;
    logic              unused_adr_bits;

    assign req             = wb_cyc_i & wb_stb_i;
    assign in_range        = (wb_adr_i[aw-1:mem_aw+2] == base_addr[aw-1:mem_aw+2]);
    assign word_idx        = wb_adr_i[mem_aw+1:2];
    assign wb_ack_o        = ack_q & req;
    assign wb_err_o        = err_q & req;
    assign wb_rty_o        = 1'b0;
    assign beat            = wb_ack_o;
    assign write_count     = count_q;
    assign unused_adr_bits = ^wb_adr_i[1:0];

    // Next burst address: only the bits under the wrap mask advance.
    always_comb begin
        case (wb_bte_i)
            2'b01:   wrap_mask = mem_aw'(4'h3);
            2'b10:   wrap_mask = mem_aw'(4'h7);
            2'b11:   wrap_mask = mem_aw'(4'hF);
            default: wrap_mask = '1;
        endcase
        burst_next = (addr_q & ~wrap_mask) | ((addr_q + mem_aw'(1)) & wrap_mask);
    end

    // Next-state, registered-handshake and read-address decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        rd_load = 1'b0;
        rd_addr = word_idx;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = word_idx;
                        ack_d   = 1'b1;
                        rd_load = 1'b1;
                        state_d = (wb_cti_i == CTI_INC) ? BURST : CLASSIC;
                    end
                end
            end
            CLASSIC: state_d = IDLE;
            BURST: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (beat) begin
                    addr_d  = burst_next;
                    rd_load = 1'b1;
                    rd_addr = burst_next;
                    if (wb_cti_i == CTI_END) state_d = IDLE;
                    else                     ack_d   = 1'b1;
                end else begin
                    ack_d = 1'b1;
                end
            end
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, handshake flags, beat address and registered read data.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (wb_rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wb_dat_o <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            if (rd_load) wb_dat_o <= mem[rd_addr];
        end
    end

    // Byte-lane writes on accepted write beats.
    // NOTE: the array has no reset so it can map onto block RAM; beats are
    // gated by the async-cleared ack, so a write cannot land during reset.
    always_ff @(posedge wb_clk) begin
        if (beat && wb_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) mem[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    // Saturating count of accepted write beats; clear wins.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            count_q <= '0;
        end else if (clear_count) begin
            count_q <= '0;
        end else if (beat && wb_we_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_daq_sample_ram.sv
// Directed self-checking bench for wb_daq_sample_ram.
module tb_wb_daq_sample_ram;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    logic        wb_clk      = 1'b0;
    logic        wb_rst      = 1'b1;
    logic [31:0] wb_adr_i    = '0;
    logic [31:0] wb_dat_i    = '0;
    logic [3:0]  wb_sel_i    = '0;
    logic        wb_we_i     = 1'b0;
    logic        wb_cyc_i    = 1'b0;
    logic        wb_stb_i    = 1'b0;
    logic [2:0]  wb_cti_i    = '0;
    logic [1:0]  wb_bte_i    = '0;
    logic        clear_count = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [15:0] write_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    wb_daq_sample_ram dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cti_i    (wb_cti_i),
        .wb_bte_i    (wb_bte_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .wb_rty_o    (wb_rty_o),
        .clear_count (clear_count),
        .write_count (write_count)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_cti_i = CTI_CLASSIC;
        wb_bte_i = 2'b00;
    endtask

    // Bounded wait for ack/err; returns at a falling edge.
    task automatic wait_ack();
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk);
            if (wb_ack_o || wb_err_o) break;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic write_classic(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_CLASSIC;
        wb_bte_i = 2'b00;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wait_ack();
        check("wr_ack", 32'(wb_ack_o), 32'd1);
        @(posedge wb_clk); #1;
        idle_bus();
    endtask

    task automatic read_classic(input logic [31:0] adr, output logic [31:0] rdata);
        wb_adr_i = adr;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b0;
        wb_cti_i = CTI_CLASSIC;
        wb_bte_i = 2'b00;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wait_ack();
        check("rd_ack", 32'(wb_ack_o), 32'd1);
        rdata = wb_dat_o;
        @(posedge wb_clk); #1;
        idle_bus();
    endtask

    initial begin
        idle_bus();

        // Reset state
        @(negedge wb_clk);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_rty", 32'(wb_rty_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_count", 32'(write_count), 32'd0);
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;

        // Classic write: 1-clock latency, 1-cycle-wide ack
        wb_adr_i = 32'h10;
        wb_dat_i = 32'hDEADBEEF;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_CLASSIC;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("cw_ack_same_cycle", 32'(wb_ack_o), 32'd0);
        @(negedge wb_clk);
        check("cw_ack_latency", 32'(wb_ack_o), 32'd1);
        @(negedge wb_clk);
        check("cw_ack_width", 32'(wb_ack_o), 32'd0);
        idle_bus();
        check("cw_count", 32'(write_count), 32'd1);
        @(posedge wb_clk); #1;
        read_classic(32'h10, rd);
        check("cr_data", rd, 32'hDEADBEEF);

        // Byte lanes
        write_classic(32'h20, 32'h11223344, 4'hF);
        write_classic(32'h20, 32'hAABBCCDD, 4'b0101);
        read_classic(32'h20, rd);
        check("sel_merge", rd, 32'h11BB33DD);

        // Wrap-4 burst write from word 6: words 6,7,4,5 <- 1,2,3,4
        wb_adr_i = 32'h18;
        wb_dat_i = 32'd1;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_INC;
        wb_bte_i = 2'b01;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("bw_ack_latency", 32'(wb_ack_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge wb_clk);
            check("bw_ack", 32'(wb_ack_o), 32'd1);
            @(posedge wb_clk); #1;
            if (b < 3) begin
                wb_dat_i = 32'(b + 2);
                wb_cti_i = (b == 2) ? CTI_END : CTI_INC;
            end
        end
        @(negedge wb_clk);
        check("bw_ack_after_end", 32'(wb_ack_o), 32'd0);
        idle_bus();
        @(posedge wb_clk); #1;
        check("bw_count", 32'(write_count), 32'd7);
        read_classic(32'h18, rd);
        check("bw_word6", rd, 32'd1);
        read_classic(32'h1C, rd);
        check("bw_word7", rd, 32'd2);
        read_classic(32'h10, rd);
        check("bw_word4", rd, 32'd3);
        read_classic(32'h14, rd);
        check("bw_word5", rd, 32'd4);
        read_classic(32'h20, rd);
        check("bw_word8_untouched", rd, 32'h11BB33DD);

        // Linear burst read of words 16..23 with a 2-cycle stb gap after beat 3
        for (int i = 0; i < 8; i++) write_classic(32'(32'h40 + 4 * i), 32'(32'hA000_0000 + i), 4'hF);
        check("pre_count", 32'(write_count), 32'd15);
        wb_adr_i = 32'h40;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_cti_i = CTI_INC;
        wb_bte_i = 2'b00;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("lb_ack_latency", 32'(wb_ack_o), 32'd0);
        for (int b = 0; b < 8; b++) begin
            @(negedge wb_clk);
            check("lb_ack", 32'(wb_ack_o), 32'd1);
            check("lb_data", wb_dat_o, 32'(32'hA000_0000 + b));
            @(posedge wb_clk); #1;
            wb_adr_i = 32'h0000_0FFC;
            if (b == 2) begin
                wb_stb_i = 1'b0;
                @(negedge wb_clk);
                check("lb_wait1_ack", 32'(wb_ack_o), 32'd0);
                @(posedge wb_clk); #1;
                @(negedge wb_clk);
                check("lb_wait2_ack", 32'(wb_ack_o), 32'd0);
                @(posedge wb_clk); #1;
                wb_stb_i = 1'b1;
            end
            if (b == 6) wb_cti_i = CTI_END;
        end
        idle_bus();

        // Out-of-range access
        write_classic(32'h0, 32'h55AA55AA, 4'hF);
        wb_adr_i = 32'h1000;
        wb_dat_i = 32'h0BAD0BAD;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_CLASSIC;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("oor_err_early", 32'(wb_err_o), 32'd0);
        @(negedge wb_clk);
        check("oor_err", 32'(wb_err_o), 32'd1);
        check("oor_ack", 32'(wb_ack_o), 32'd0);
        check("oor_rty", 32'(wb_rty_o), 32'd0);
        @(negedge wb_clk);
        check("oor_err_width", 32'(wb_err_o), 32'd0);
        check("oor_ack_late", 32'(wb_ack_o), 32'd0);
        idle_bus();
        @(posedge wb_clk); #1;
        check("oor_count", 32'(write_count), 32'd16);
        read_classic(32'h0, rd);
        check("oor_mem", rd, 32'h55AA55AA);

        // Saturation: long sel=0000 linear burst, counted but data preserved
        wb_adr_i = 32'h0;
        wb_dat_i = 32'hFFFF_FFFF;
        wb_sel_i = 4'h0;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_INC;
        wb_bte_i = 2'b00;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        for (int b = 0; b < 65519; b++) begin
            if (b == 65518) wb_cti_i = CTI_END;
            @(posedge wb_clk); #1;
        end
        idle_bus();
        check("sat_reach", 32'(write_count), 32'h0000_FFFF);
        read_classic(32'h40, rd);
        check("sel0_preserve", rd, 32'hA000_0000);
        write_classic(32'h30, 32'h12345678, 4'hF);
        check("sat_hold", 32'(write_count), 32'h0000_FFFF);

        // Clear coinciding with a write beat
        wb_adr_i = 32'h34;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_CLASSIC;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk);
        @(negedge wb_clk);
        check("clr_ack", 32'(wb_ack_o), 32'd1);
        clear_count = 1'b1;
        @(posedge wb_clk); #1;
        clear_count = 1'b0;
        idle_bus();
        check("clr_count", 32'(write_count), 32'd0);
        write_classic(32'h34, 32'h1, 4'hF);
        check("post_clr_count", 32'(write_count), 32'd1);

        // Reset mid-burst
        write_classic(32'h8C, 32'hC0FFEE00, 4'hF);
        wb_adr_i = 32'h80;
        wb_dat_i = 32'h7777_0000;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cti_i = CTI_INC;
        wb_bte_i = 2'b00;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        for (int b = 0; b < 3; b++) begin
            @(posedge wb_clk); #1;
            wb_dat_i = 32'(32'h7777_0000 + b + 1);
        end
        @(negedge wb_clk);
        check("mid_ack", 32'(wb_ack_o), 32'd1);
        check("mid_count", 32'(write_count), 32'd5);
        wb_rst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        check("mid_rst_err", 32'(wb_err_o), 32'd0);
        check("mid_rst_count", 32'(write_count), 32'd0);
        check("mid_rst_dat", wb_dat_o, 32'h0);
        @(posedge wb_clk); #1;
        idle_bus();
        wb_rst = 1'b0;
        read_classic(32'h8C, rd);
        check("rst_write_suppressed", rd, 32'hC0FFEE00);
        read_classic(32'h88, rd);
        check("rst_prior_beat", rd, 32'h7777_0002);
        check("end_rty", 32'(wb_rty_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
